// File: rtl/mem_bus_ctrl_pkg.sv
// Shared address map, FSM encoding and decode helper for the 6502 memory/bus controller.
package mem_bus_ctrl_pkg;

    localparam logic [15:0] RAM_BASE      = 16'h0000;
    localparam logic [15:0] RAM_TOP       = 16'h07FF;
    localparam logic [15:0] EXT_BASE      = 16'h8000;
    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;
    localparam int          RAM_AW        = 11;
    localparam int          RAM_DEPTH     = 2048;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_RAM  = 4'b0010,
        ST_EXT  = 4'b0100,
        ST_RESP = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_EXT  = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    function automatic region_t decode_region(input logic [15:0] addr);
        if ((addr - RAM_BASE) <= (RAM_TOP - RAM_BASE)) return REG_RAM;
        if (addr >= EXT_BASE)                          return REG_EXT;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_sp_ram.sv
// Single-port 2048x8 synchronous RAM, registered read, no reset.
// Read data appears the cycle after an enabled read and holds until the next one.
module mem_bus_ctrl_sp_ram
    import mem_bus_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [RAM_DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) mem_q[addr] <= wdata;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// 6502 memory/bus controller: on-chip RAM, external byte bus with wait states and timeout.
// Core stalls until the one-cycle cpu_ready pulse; requests outside IDLE are ignored.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int EXT_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        bus_err,
    output logic        ext_cs,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack
);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_from_ram_q, rd_from_ram_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  to_q, to_d;
    logic        ram_en;
    logic [7:0]  ram_rdata;
    logic        ack_take;
    logic        to_expire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            rd_from_ram_q <= 1'b0;
            wait_q        <= '0;
            to_q          <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            rd_from_ram_q <= rd_from_ram_d;
            wait_q        <= wait_d;
            to_q          <= to_d;
        end
    end

    // Ack is only honoured once the wait states are spent; it beats a coincident timeout.
    assign ack_take  = (wait_q == 4'd0) && ext_ack;
    assign to_expire = (to_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        rd_from_ram_d = rd_from_ram_q;
        wait_d        = wait_q;
        to_d          = to_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    unique case (decode_region(cpu_addr))
                        REG_RAM: state_d = ST_RAM;
                        REG_EXT: begin
                            state_d = ST_EXT;
                            wait_d  = 4'(EXT_WAIT);
                            to_d    = '0;
                        end
                        default: begin
                            state_d       = ST_RESP;
                            rdata_d       = UNMAPPED_DATA;
                            rd_from_ram_d = 1'b0;
                            err_d         = 1'b1;
                        end
                    endcase
                end
            end
            ST_RAM: begin
                if (!we_q) rd_from_ram_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_EXT: begin
                to_d = to_q + 8'd1;
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end
                if (ack_take) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d       = ext_rdata;
                        rd_from_ram_d = 1'b0;
                    end
                end else if (to_expire) begin
                    state_d       = ST_RESP;
                    rdata_d       = UNMAPPED_DATA;
                    rd_from_ram_d = 1'b0;
                    err_d         = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        bus_err   = 1'b0;
        ext_cs    = 1'b0;
        ext_we    = 1'b0;
        ram_en    = 1'b0;
        unique case (state_q)
            ST_RAM:  ram_en = 1'b1;
            ST_EXT: begin
                ext_cs = 1'b1;
                ext_we = we_q;
            end
            ST_RESP: begin
                cpu_ready = 1'b1;
                bus_err   = err_q;
            end
            default: ;
        endcase
    end

    // The RAM's own output register is the read-data holder after a RAM read.
    assign cpu_rdata = rd_from_ram_q ? ram_rdata : rdata_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;

    mem_bus_ctrl_sp_ram u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule
